// File: rtl/alu_share_arbiter_pkg.sv
// Shared ALU definitions: control codes, arbiter FSM states and the
// legal-opcode test used by the illegal-op check (ALU_ILLEGAL_OP_CHECK_EN).
package alu_pkg;

    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_SUB = 4'b0110;
    localparam logic [3:0] ALU_SLT = 4'b0111;
    localparam logic [3:0] ALU_NOR = 4'b1100;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } alu_fsm_t;

    function automatic logic is_legal_alu_op(input logic [3:0] ctrl);
        case (ctrl)
            ALU_AND, ALU_OR, ALU_ADD, ALU_SUB, ALU_SLT, ALU_NOR: return 1'b1;
            default:                                           return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/alu_share_arbiter_rr_arbiter.sv
// Combinational round-robin arbiter: first set request at or above ptr,
// wrapping from NUM_REQ-1 back to 0. Outputs one-hot grant and its index.
module rr_arbiter #(
    parameter int NUM_REQ = 2,
    parameter int IDX_W   = 1
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   ptr,
    output logic [NUM_REQ-1:0] grant,
    output logic [IDX_W-1:0]   grant_idx,
    output logic               any
);

    localparam int SW = IDX_W + 1;

    logic [SW-1:0]    sum;
    logic [IDX_W-1:0] cand;

    // Scan farthest-from-ptr first so the candidate nearest ptr overwrites last
    always_comb begin
        grant     = '0;
        grant_idx = '0;
        any       = 1'b0;
        sum       = '0;
        cand      = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            sum = {1'b0, ptr} + SW'(i);
            if (sum >= SW'(NUM_REQ))
                sum = sum - SW'(NUM_REQ);
            cand = sum[IDX_W-1:0];
            if (req[cand]) begin
                grant_idx = cand;
                any       = 1'b1;
            end
        end
        if (any)
            grant[grant_idx] = 1'b1;
    end

endmodule

// File: rtl/alu_share_arbiter.sv
// Shares one external ALU among NUM_REQ requesters with round-robin grant.
// One operation in flight: IDLE (grant) -> EXEC (ALU evaluates) -> RESP.
// Optional build macro ALU_ILLEGAL_OP_CHECK_EN: illegal opcodes skip EXEC
// and respond with result 0, zero 1, err 1.
module alu_share_arbiter
    import alu_pkg::*;
#(
    parameter int NUM_REQ = 2,
    parameter int DATA_W  = 32
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [NUM_REQ-1:0]        req_valid,
    output logic [NUM_REQ-1:0]        req_ready,
    input  logic [NUM_REQ*DATA_W-1:0] req_operand_a,
    input  logic [NUM_REQ*DATA_W-1:0] req_operand_b,
    input  logic [NUM_REQ*4-1:0]      req_ctrl,
    output logic [NUM_REQ-1:0]        rsp_valid,
    input  logic [NUM_REQ-1:0]        rsp_ready,
    output logic [DATA_W-1:0]         rsp_result,
    output logic                      rsp_zero,
    output logic                      rsp_err,
    output logic [DATA_W-1:0]         alu_operand_a,
    output logic [DATA_W-1:0]         alu_operand_b,
    output logic [3:0]                alu_control_signal,
    input  logic [DATA_W-1:0]         alu_result,
    input  logic                      alu_zero
);

    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    alu_fsm_t           state;
    logic [IDX_W-1:0]   rr_ptr;
    logic [IDX_W-1:0]   owner;
    logic [IDX_W-1:0]   grant_idx;
    logic [IDX_W-1:0]   next_ptr;
    logic [NUM_REQ-1:0] grant;
    logic               any_valid;
    logic               accept;
    logic               skip_exec;
    logic [DATA_W-1:0]  op_a, op_b, res;
    logic [3:0]         op_ctrl;
    logic               zero;
    logic [DATA_W-1:0]  sel_a, sel_b;
    logic [3:0]         sel_ctrl;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_arb (
        .req       (req_valid),
        .ptr       (rr_ptr),
        .grant     (grant),
        .grant_idx (grant_idx),
        .any       (any_valid)
    );

    // Ready is masked by reset so every output reads 0 while rst_n is low
    assign accept    = rst_n && (state == IDLE) && any_valid;
    assign req_ready = accept ? grant : '0;

    assign sel_a    = req_operand_a[grant_idx*DATA_W +: DATA_W];
    assign sel_b    = req_operand_b[grant_idx*DATA_W +: DATA_W];
    assign sel_ctrl = req_ctrl[grant_idx*4 +: 4];

    assign next_ptr = (owner == IDX_W'(NUM_REQ - 1)) ? '0 : owner + IDX_W'(1);

    assign alu_operand_a      = op_a;
    assign alu_operand_b      = op_b;
    assign alu_control_signal = op_ctrl;
    assign rsp_result         = res;
    assign rsp_zero           = zero;

`ifdef ALU_ILLEGAL_OP_CHECK_EN
    logic err;

    // err is re-evaluated on every accept, so a legal op clears it
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            err <= 1'b0;
        else if (accept)
            err <= ~is_legal_alu_op(sel_ctrl);
    end

    assign skip_exec = ~is_legal_alu_op(sel_ctrl);
    assign rsp_err   = err;
`else
    assign skip_exec = 1'b0;
    assign rsp_err   = 1'b0;
`endif

    // Only the owning requester sees a response valid
    always_comb begin
        rsp_valid = '0;
        if (state == RESP)
            rsp_valid[owner] = 1'b1;
    end

    // Grant/latch, ALU capture and response handshake sequencing
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            rr_ptr  <= '0;
            owner   <= '0;
            op_a    <= '0;
            op_b    <= '0;
            op_ctrl <= '0;
            res     <= '0;
            zero    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        op_a    <= sel_a;
                        op_b    <= sel_b;
                        op_ctrl <= sel_ctrl;
                        owner   <= grant_idx;
                        if (skip_exec) begin
                            res   <= '0;
                            zero  <= 1'b1;
                            state <= RESP;
                        end else begin
                            state <= EXEC;
                        end
                    end
                end
                EXEC: begin
                    res   <= alu_result;
                    zero  <= alu_zero;
                    state <= RESP;
                end
                RESP: begin
                    if (rsp_ready[owner]) begin
                        rr_ptr <= next_ptr;
                        state  <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
